receiver_74lv595: RTL and testbench
===================================

# receiver_74lv595

Panel-side receiver for the four-lane 74LV595 serial output stream driven by the SoC. It oversamples RCLK, SRCLK and SER_0..SER_3 in the local clock domain and rebuilds the four 16-bit words that a chain of 74LV595 parts would present. The block runs on the panel board FPGA and also serves as a loopback monitor in SoC benches. It mirrors the 74LV595 behaviour: SRCLK shifts, RCLK latches. It adds a frame-valid pulse and frame-length checking.

## Interface
Parameters:
- WIDTH, 16, bits per lane, which is also the required SRCLK edges per frame.
- ERR_CNT_W, 8, width of the saturating frame-error counter.

Ports:
- clk  input  1  system clock; the only clock in the block.
- resetn  input  1  reset; asynchronous, active-low.
- RCLK  input  1  storage-latch clock from the transmitter; asynchronous to clk.
- SRCLK  input  1  shift clock from the transmitter; asynchronous to clk.
- SER_0..SER_3  input  1 each  serial data lanes 0..3.
- data_0..data_3  output  WIDTH each  latched words for lanes 0..3.
- frame_valid  output  1  one-cycle pulse when data_0..3 update.
- frame_err  output  1  one-cycle pulse, coincident with frame_valid, when the frame length is not WIDTH.
- err_cnt  output  ERR_CNT_W  saturating count of frame_err pulses.

## Operation
- Synchronisation:
  - RCLK, SRCLK and every SER lane pass through two flops, then a third stage for edge detection.
  - All inputs use identical depth, so SER is sampled in alignment with the detected SRCLK edge.
- SRCLK rise:
  - Each lane shift register does `sr <= {sr[WIDTH-2:0], ser_sync}`.
  - The first bit sent ends in bit WIDTH-1, so data is MSB first.
- RCLK rise:
  - data_n <= sr_n for all lanes.
  - frame_valid pulses.
- Shift registers are not cleared by a latch. This matches the 74LV595.
- Simultaneous SRCLK and RCLK rise in the same cycle:
  - The latch takes the pre-shift contents.
  - The shift still occurs.
  - The frame check (see Configuration) uses the pre-shift count, and the count afterwards is 1.
- Reset values: all flops are 0.
  - data_0..3 = 0, frame_valid = 0, frame_err = 0, err_cnt = 0.
- Reset asserted mid-frame discards the partial frame.
- Falling edges of RCLK and SRCLK have no effect.

## Timing
- Let N be the first clk edge that samples a pin edge high.
- The sync stages hold the value at N+1. The rise strobe is valid in the cycle after N+1, and the action registers at edge N+2.
- For RCLK, data_n, frame_valid and frame_err update at N+2. Pin-to-output latency is therefore 3 clk edges.
- Input requirements:
  - SRCLK and RCLK high ≥3 clk periods and low ≥3 clk periods.
  - SER stable from 2 clk periods before to 2 clk periods after the SRCLK rise at the pins.
  - RCLK rise ≥3 clk periods after the last SRCLK rise of the frame. The simultaneous case is defined above but is not a normal operating mode.
- frame_valid and frame_err are exactly one cycle wide.
- err_cnt updates on the same edge as frame_err.

## Configuration
- RECEIVER_FRAME_CHECK_EN defined:
  - A 5-bit counter counts SRCLK rises since the last RCLK rise or reset, saturating at 31.
  - On RCLK rise, if the count ≠ WIDTH, frame_err pulses and err_cnt increments, saturating at all-ones.
  - The count then returns to 0, or to 1 in the simultaneous case.
- RECEIVER_FRAME_CHECK_EN undefined:
  - No counter is built.
  - frame_err and err_cnt are tied to 0.
  - Data behaviour is identical in both builds.

## Structure
- Shared package panel_serial_pkg holds:
  - LANE_COUNT = 4.
  - FRAME_BITS = 16.
  - BIT_CNT_W = 5.
  - A typedef for a lane word.
- Sub-module sync_rise: a two-flop synchroniser plus edge stage, with outputs `sync` and `rise`. It is instantiated once per input (six instances).
- The top level holds the lane shift registers, output latches and frame checker.

## Test plan
- Reset release, no activity:
  - data_0..3 = 0, frame_valid = 0, err_cnt = 0 for 100 cycles.
- Single frame of 16 SRCLK pulses (4 clk high / 4 clk low), lanes = 16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF, MSB first, then RCLK:
  - Outputs match exactly.
  - frame_valid is one pulse, 3 edges after the RCLK pin rise.
  - frame_err = 0.
- Frame of 15 SRCLK pulses, then RCLK:
  - Check build: frame_err pulses and err_cnt = 1.
  - No-check build: frame_err = 0.
  - In both builds data equals the 15-bit-shifted register contents.
- RCLK with no intervening SRCLK after a valid frame:
  - Data is unchanged and frame_valid pulses.
  - Check build: frame_err = 1.
- Same-cycle SRCLK and RCLK rise after 16 shifts of 16'h1234 on lane 0:
  - data_0 = 16'h1234, frame_err = 0.
  - A following 15 shifts plus RCLK gives no frame_err.
- resetn asserted after 8 shifts, then released, then a full frame of 16'hBEEF:
  - data_0 = 16'hBEEF and err_cnt = 0.
- 300 short frames in a check build:
  - err_cnt saturates at 255 with no wrap.

Source files
------------

// File: rtl/panel_serial_pkg.sv
// Shared constants and types for the panel-side 74LV595 serial receiver.
package panel_serial_pkg;

    localparam int LANE_COUNT = 4;
    localparam int FRAME_BITS = 16;
    localparam int BIT_CNT_W  = 5;

    typedef logic [FRAME_BITS-1:0] lane_word_t;

    // Saturating increment for the SRCLK edge counter.
    function automatic logic [BIT_CNT_W-1:0] bit_cnt_inc(input logic [BIT_CNT_W-1:0] cnt);
        logic [BIT_CNT_W-1:0] nxt;
        if (cnt == {BIT_CNT_W{1'b1}}) begin
            nxt = cnt;
        end else begin
            nxt = cnt + {{(BIT_CNT_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sync_rise.sv
// Two-flop synchroniser followed by an edge stage; rise is high for one clk
// cycle after the synchronised input goes from 0 to 1.
module sync_rise (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic sync,
    output logic rise
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // synchroniser chain plus previous-value stage for edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign sync = sync_r;
    assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/receiver_74lv595.sv
// Four-lane 74LV595 stream receiver: SRCLK shifts, RCLK latches, with a
// frame-length checker built only when RECEIVER_FRAME_CHECK_EN is defined.
module receiver_74lv595
    import panel_serial_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 RCLK,
    input  logic                 SRCLK,
    input  logic                 SER_0,
    input  logic                 SER_1,
    input  logic                 SER_2,
    input  logic                 SER_3,
    output logic [WIDTH-1:0]     data_0,
    output logic [WIDTH-1:0]     data_1,
    output logic [WIDTH-1:0]     data_2,
    output logic [WIDTH-1:0]     data_3,
    output logic                 frame_valid,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int PIN_COUNT = LANE_COUNT + 2;

    logic [PIN_COUNT-1:0]  pin_s;
    logic [PIN_COUNT-1:0]  sync_s;
    logic [PIN_COUNT-1:0]  rise_s;
    logic [LANE_COUNT-1:0] ser_s;
    logic                  srclk_rise_s;
    logic                  rclk_rise_s;

    logic [WIDTH-1:0] sr_r   [LANE_COUNT];
    logic [WIDTH-1:0] data_r [LANE_COUNT];
    logic             frame_valid_r;

    // Identical sync depth on every pin keeps SER aligned with the SRCLK edge.
    assign pin_s = {RCLK, SRCLK, SER_3, SER_2, SER_1, SER_0};

    for (genvar i = 0; i < PIN_COUNT; i++) begin : g_sync
        sync_rise u_sync_rise (
            .clk    (clk),
            .resetn (resetn),
            .d      (pin_s[i]),
            .sync   (sync_s[i]),
            .rise   (rise_s[i])
        );
    end

    assign ser_s        = sync_s[LANE_COUNT-1:0];
    assign srclk_rise_s = rise_s[LANE_COUNT];
    assign rclk_rise_s  = rise_s[LANE_COUNT+1];

    // lane shift registers, output latches and frame-valid strobe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int l = 0; l < LANE_COUNT; l++) begin
                sr_r[l]   <= {WIDTH{1'b0}};
                data_r[l] <= {WIDTH{1'b0}};
            end
            frame_valid_r <= 1'b0;
        end else begin
            for (int l = 0; l < LANE_COUNT; l++) begin
                if (srclk_rise_s) begin
                    sr_r[l] <= {sr_r[l][WIDTH-2:0], ser_s[l]};
                end
                // non-blocking read gives the pre-shift word on a coincident edge
                if (rclk_rise_s) begin
                    data_r[l] <= sr_r[l];
                end
            end
            frame_valid_r <= rclk_rise_s;
        end
    end

    assign data_0      = data_r[0];
    assign data_1      = data_r[1];
    assign data_2      = data_r[2];
    assign data_3      = data_r[3];
    assign frame_valid = frame_valid_r;

`ifdef RECEIVER_FRAME_CHECK_EN
    logic [BIT_CNT_W-1:0] bit_cnt_r;
    logic                 frame_err_r;
    logic [ERR_CNT_W-1:0] err_cnt_r;

    // SRCLK edge counter and saturating frame-error counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt_r   <= {BIT_CNT_W{1'b0}};
            frame_err_r <= 1'b0;
            err_cnt_r   <= {ERR_CNT_W{1'b0}};
        end else if (rclk_rise_s) begin
            frame_err_r <= (bit_cnt_r != BIT_CNT_W'(WIDTH));
            if ((bit_cnt_r != BIT_CNT_W'(WIDTH)) && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
                err_cnt_r <= err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
            end
            // a coincident shift becomes the first bit of the next frame
            bit_cnt_r <= {{(BIT_CNT_W-1){1'b0}}, srclk_rise_s};
        end else begin
            frame_err_r <= 1'b0;
            if (srclk_rise_s) begin
                bit_cnt_r <= bit_cnt_inc(bit_cnt_r);
            end
        end
    end

    assign frame_err = frame_err_r;
    assign err_cnt   = err_cnt_r;
`else
    assign frame_err = 1'b0;
    assign err_cnt   = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_receiver_74lv595.sv
// Directed bench for receiver_74lv595; expectations adapt to whether
// RECEIVER_FRAME_CHECK_EN is defined.
module tb_receiver_74lv595;

    logic        clk;
    logic        resetn;
    logic        RCLK;
    logic        SRCLK;
    logic        SER_0, SER_1, SER_2, SER_3;
    logic [15:0] data_0, data_1, data_2, data_3;
    logic        frame_valid;
    logic        frame_err;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    receiver_74lv595 #(.WIDTH(16), .ERR_CNT_W(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .RCLK        (RCLK),
        .SRCLK       (SRCLK),
        .SER_0       (SER_0),
        .SER_1       (SER_1),
        .SER_2       (SER_2),
        .SER_3       (SER_3),
        .data_0      (data_0),
        .data_1      (data_1),
        .data_2      (data_2),
        .data_3      (data_3),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RECEIVER_FRAME_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_bits(input logic [3:0] b);
        {SER_3, SER_2, SER_1, SER_0} = b;
        repeat (4) tick();
        SRCLK = 1'b1;
        repeat (4) tick();
        SRCLK = 1'b0;
    endtask

    // Sends the top nbits of each word, MSB first.
    task automatic send_frame(input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3, input int nbits);
        for (int i = 15; i > 15 - nbits; i--) begin
            send_bits({w3[i], w2[i], w1[i], w0[i]});
        end
    endtask

    // Raises RCLK (optionally with SRCLK) and watches the strobes.
    task automatic pulse_rclk(input logic with_srclk, output int hits, output int pos,
                              output int err_hits);
        hits = 0; pos = -1; err_hits = 0;
        repeat (4) tick();
        RCLK = 1'b1;
        if (with_srclk) SRCLK = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (frame_valid) begin hits++; pos = i; end
            if (frame_err) err_hits++;
        end
        RCLK = 1'b0;
        SRCLK = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        int hits, pos, eh;
        logic [31:0] acc;
        resetn = 1'b0; RCLK = 1'b0; SRCLK = 1'b0;
        {SER_3, SER_2, SER_1, SER_0} = 4'h0;
        repeat (5) tick();
        resetn = 1'b1;

        // idle after reset
        acc = 32'h0;
        for (int i = 0; i < 100; i++) begin
            tick();
            acc = acc | {15'h0, frame_valid, data_0 | data_1 | data_2 | data_3};
            acc[24 +: 8] = acc[24 +: 8] | err_cnt;
        end
        check_val("idle_data", {16'h0, acc[15:0]}, 32'h0);
        check_val("idle_fv", {31'h0, acc[16]}, 32'h0);
        check_val("idle_errcnt", {24'h0, acc[31:24]}, 32'h0);

        // full frame
        send_frame(16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF, 16);
        pulse_rclk(1'b0, hits, pos, eh);
        check_val("f1_d0", data_0, 16'hA5C3);
        check_val("f1_d1", data_1, 16'h0001);
        check_val("f1_d2", data_2, 16'h8000);
        check_val("f1_d3", data_3, 16'hFFFF);
        check_val("f1_fv_hits", hits, 1);
        check_val("f1_fv_pos", pos, 2);
        check_val("f1_err", eh, 0);

        // 15-bit frame: previous LSB ends up in bit 15
        send_frame(16'h1357, 16'hFFFE, 16'h0003, 16'h0000, 15);
        pulse_rclk(1'b0, hits, pos, eh);
        check_val("s15_d0", data_0, 16'h89AB);
        check_val("s15_d1", data_1, 16'hFFFF);
        check_val("s15_d2", data_2, 16'h0001);
        check_val("s15_d3", data_3, 16'h8000);
        check_val("s15_err", eh, CHK ? 1 : 0);
        check_val("s15_errcnt", err_cnt, CHK ? 1 : 0);

        // valid frame then an empty latch
        send_frame(16'h0F0F, 16'hF0F0, 16'h5555, 16'hAAAA, 16);
        pulse_rclk(1'b0, hits, pos, eh);
        check_val("f2_d0", data_0, 16'h0F0F);
        check_val("f2_err", eh, 0);
        pulse_rclk(1'b0, hits, pos, eh);
        check_val("e_d0", data_0, 16'h0F0F);
        check_val("e_d3", data_3, 16'hAAAA);
        check_val("e_fv_hits", hits, 1);
        check_val("e_err", eh, CHK ? 1 : 0);
        check_val("e_errcnt", err_cnt, CHK ? 2 : 0);

        // coincident SRCLK/RCLK: latch sees pre-shift, shift starts next frame
        send_frame(16'h1234, 16'h0000, 16'h0000, 16'h0000, 16);
        {SER_3, SER_2, SER_1, SER_0} = 4'h1;  // bit 15 of 16'hCAFE
        pulse_rclk(1'b1, hits, pos, eh);
        check_val("sim_d0", data_0, 16'h1234);
        check_val("sim_fv_hits", hits, 1);
        check_val("sim_err", eh, 0);
        send_frame(16'h95FC, 16'h0000, 16'h0000, 16'h0000, 15);  // 16'hCAFE[14:0]
        pulse_rclk(1'b0, hits, pos, eh);
        check_val("sim_next_d0", data_0, 16'hCAFE);
        check_val("sim_next_err", eh, 0);
        check_val("sim_errcnt", err_cnt, CHK ? 2 : 0);

        // reset mid-frame
        send_frame(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 8);
        resetn = 1'b0;
        repeat (3) tick();
        check_val("rst_d0", data_0, 16'h0000);
        check_val("rst_errcnt", err_cnt, 0);
        resetn = 1'b1;
        repeat (4) tick();
        send_frame(16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 16);
        pulse_rclk(1'b0, hits, pos, eh);
        check_val("beef_d0", data_0, 16'hBEEF);
        check_val("beef_err", eh, 0);
        check_val("beef_errcnt", err_cnt, 0);

        // saturation with empty frames
        for (int i = 1; i <= 300; i++) begin
            pulse_rclk(1'b0, hits, pos, eh);
            if (i == 254) check_val("sat_254", err_cnt, CHK ? 254 : 0);
            if (i == 255) check_val("sat_255", err_cnt, CHK ? 255 : 0);
        end
        check_val("sat_300", err_cnt, CHK ? 255 : 0);
        check_val("sat_d0", data_0, 16'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
